platform_manager: RTL and testbench
===================================

// Module: platform_manager
// PURPOSE
//  Owns the 8 platforms the doodle physics block collides against; drives the Platform_X/Platform_Y
//  arrays and platform_size it consumes. Scrolls the field down when the doodle climbs above a
//  scroll line, respawns platforms that fall off screen at a pseudo-random X, counts score.
//  Sits between the game-state FSM/doodle block and the sprite renderer.
// PARAMETERS
//  W            640  screen width (px)
//  H            480  screen height (px); wrap modulus for platform Y
//  X_MIN        140  leftmost playfield column
//  X_MAX        499  rightmost playfield column
//  PLAT_SIZE    60   platform width (px), driven on platform_size
//  SPACING      60   vertical gap between platforms (PLAT_N*SPACING == H required)
//  SCROLL_LINE  160  doodle Y above which the field scrolls
//  MAX_SCROLL   12   max scroll per frame (px)
// PORTS
//  Clk             in   1      50 MHz system clock
//  Reset_n         in   1      asynchronous, active-low reset
//  frame_clk_edge  in   2      2'b01 = rising edge of ~60 Hz frame clock (one Clk wide)
//  state           in   8      game state; 8'd1 = playing, other values = not playing
//  Doodle_Y        in   10     doodle top-edge Y (unsigned)
//  Platform_X      out  10x8   platform left X, index 0..7
//  Platform_Y      out  10x8   platform top Y, index 0..7
//  platform_size   out  8      constant PLAT_SIZE
//  score           out  16     platforms respawned this game, saturating
//  busy            out  1      high while LOAD or UPDATE sweep in progress
// BEHAVIOUR
//  Reset: Platform_Y[i]=H-40-i*SPACING (440,380,...,20); Platform_X[i]=(W-PLAT_SIZE)/2=290;
//   score=0; busy=0; FSM=IDLE; LFSR=16'hACE1; idx=0. Applies immediately, incl. mid-sweep.
//  LFSR: 16-bit Fibonacci x^16+x^14+x^13+x^11+1, advances every Clk in all states, never zero.
//  Random X: r=lfsr[8:0]; RANGE=X_MAX+1-X_MIN-PLAT_SIZE (300); r>=RANGE ? r-RANGE : r; X=X_MIN+r.
//   Result always in [140,439]; requires 256<=RANGE<=511.
//  FSM IDLE: outputs held. state==1 while prev_state!=1 (registered) -> LOAD, idx=0.
//  FSM LOAD: one platform per Clk, idx 0..7: Y=reset layout; X=290 for idx 0, random X otherwise;
//   score=0. After idx 7 -> RUN. busy=1. Total 8 cycles.
//  FSM RUN: on frame_clk_edge==2'b01 with state==1: scroll=(Doodle_Y<SCROLL_LINE) ?
//   min(SCROLL_LINE-Doodle_Y, MAX_SCROLL) : 0, latched. scroll==0 -> stay RUN; else UPDATE, idx=0.
//   state!=1 in RUN -> IDLE.
//  FSM UPDATE: one platform per Clk, idx 0..7: s=Platform_Y[idx]+scroll (10-bit, max 491, no overflow);
//   s>=H -> Y=s-H, X=random X, score+=1 (saturate at 16'hFFFF); else Y=s, X unchanged.
//   After idx 7 -> RUN if state==1 else IDLE. Sweep always completes once started. busy=1.
//  Latency: frame edge at cycle T -> platform idx k updated at end of cycle T+1+k; all done by T+8.
//   Values visible during the edge cycle are the previous frame's (doodle samples consistently).
//  Frame edges arriving during LOAD/UPDATE are ignored (no queueing).
//  Simultaneous game-start and frame edge in IDLE: start wins; frame edge dropped.
//  Two platforms wrapping in one sweep: each gets independent LFSR sample (LFSR advanced between).
// STRUCTURE
//  doodle_pkg: PLAT_N=8, typedef enum {IDLE,LOAD,RUN,UPDATE} plat_fsm_e, LFSR_SEED, STATE_PLAY=8'd1.
//  Sub-module lfsr16 (Clk, Reset_n, out[15:0]); range fold and FSM stay in platform_manager.
// TESTING
//  1 Pulse Reset_n low -> Y={440,380,320,260,200,140,80,20}, all X=290, score=0, busy=0.
//  2 state 0->1 -> busy high exactly 8 Clk; X[0]=290, X[1..7] in [140,439]; Y equals reset layout.
//  3 RUN, Doodle_Y=100, edge -> scroll=12; after 8 Clk Y={452,392,...,32}; score unchanged.
//  4 Y[0]=470, Doodle_Y=150, edge -> scroll=10, Y[0]=0, X[0] in range, score=1; others +10.
//  5 Doodle_Y=200, edge -> no Y/X change, busy stays 0; second edge mid-UPDATE -> ignored.
//  6 Reset_n low at UPDATE idx 3 -> reset values same cycle; score sat: preload FFFF, wrap -> FFFF.

Source files
------------

// File: rtl/doodle_pkg.sv
// ---------------------------------------------------------------------------
// doodle_pkg
//   Shared constants, types and small helpers for the doodle platform logic.
//   Geometry is in screen pixels; all platform coordinates are 10-bit.
// ---------------------------------------------------------------------------
package doodle_pkg;

  localparam int W           = 640;  // screen width
  localparam int H           = 480;  // screen height, wrap modulus for platform Y
  localparam int X_MIN       = 140;  // leftmost playfield column
  localparam int X_MAX       = 499;  // rightmost playfield column
  localparam int PLAT_SIZE   = 60;   // platform width
  localparam int SPACING     = 60;   // vertical gap; PLAT_N * SPACING == H
  localparam int SCROLL_LINE = 160;  // doodle Y above which the field scrolls
  localparam int MAX_SCROLL  = 12;   // per-frame scroll clamp
  localparam int PLAT_N      = 8;

  // Width of the window a platform's left edge may occupy (300). The fold
  // below needs this in [256, 511] so one subtraction maps 9 random bits in.
  localparam int X_RANGE = X_MAX + 1 - X_MIN - PLAT_SIZE;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [7:0]  STATE_PLAY = 8'd1;

  typedef logic [9:0] coord_t;

  localparam coord_t X_CENTER = coord_t'((W - PLAT_SIZE) / 2);  // 290

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    UPDATE
  } plat_fsm_e;

  // Start-of-game Y for platform idx: 440, 380, ..., 20.
  function automatic coord_t layout_y(input logic [2:0] idx);
    return coord_t'(H - 40) - coord_t'(SPACING) * coord_t'(idx);
  endfunction

  // Map 9 random bits onto [X_MIN, X_MIN + X_RANGE - 1].
  function automatic coord_t fold_x(input logic [8:0] rnd);
    logic [8:0] r;
    r = rnd;
    if (r >= 9'(X_RANGE)) r = r - 9'(X_RANGE);
    return coord_t'(X_MIN) + coord_t'(r);
  endfunction

endpackage

// File: rtl/platform_manager_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
//   Free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
//   Shifts right; the feedback of taps 0,2,3,5 enters at bit 15. Maximal
//   length, so a non-zero seed never reaches the all-zero lock-up state.
// Ports
//   Clk      in   system clock
//   Reset_n  in   asynchronous active-low reset (loads LFSR_SEED)
//   out      out  current LFSR state, advances every Clk
// ---------------------------------------------------------------------------
module lfsr16
  import doodle_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  output logic [15:0] out
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        feedback;

  assign feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign lfsr_d   = {feedback, lfsr_q[15:1]};

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of the others, matching real hardware ordering.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/platform_manager.sv
// ---------------------------------------------------------------------------
// platform_manager
//   Owns the eight platforms the doodle collides against. On game start it
//   loads the initial layout (one platform per clock), and on each frame edge
//   while playing it scrolls the field down when the doodle is above the
//   scroll line, respawning platforms that leave the bottom at a random X and
//   counting each respawn as score.
// Ports
//   Clk            in   50 MHz system clock
//   Reset_n        in   asynchronous active-low reset
//   frame_clk_edge in   2'b01 marks the rising edge of the frame clock
//   state          in   game state, STATE_PLAY while playing
//   Doodle_Y       in   doodle top-edge Y
//   Platform_X     out  platform left X, index 0..7
//   Platform_Y     out  platform top Y, index 0..7
//   platform_size  out  constant platform width
//   score          out  platforms respawned this game, saturating
//   busy           out  high during the LOAD or UPDATE sweep
// ---------------------------------------------------------------------------
module platform_manager
  import doodle_pkg::*;
(
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [1:0]                  frame_clk_edge,
  input  logic [7:0]                  state,
  input  logic [9:0]                  Doodle_Y,
  output logic [PLAT_N-1:0][9:0]      Platform_X,
  output logic [PLAT_N-1:0][9:0]      Platform_Y,
  output logic [7:0]                  platform_size,
  output logic [15:0]                 score,
  output logic                        busy
);

  plat_fsm_e               fsm_q, fsm_d;
  logic [2:0]              idx_q, idx_d;
  logic [3:0]              scroll_q, scroll_d;
  logic [PLAT_N-1:0][9:0]  x_q, x_d;
  logic [PLAT_N-1:0][9:0]  y_q, y_d;
  logic [15:0]             score_q, score_d;
  logic                    busy_q, busy_d;
  logic                    prev_play_q;

  logic [15:0] lfsr;
  logic        lfsr_hi_unused;
  coord_t      rand_x;
  logic        playing;
  logic        start;
  logic        frame_edge;
  logic [9:0]  dy_gap;
  logic [3:0]  scroll_calc;
  logic [9:0]  sum;

  lfsr16 u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .out     (lfsr)
  );

  // Only the low 9 bits feed the X fold.
  assign lfsr_hi_unused = ^lfsr[15:9];
  assign rand_x         = fold_x(lfsr[8:0]);

  assign playing    = (state == STATE_PLAY);
  // Game start is the first cycle of STATE_PLAY, not the level.
  assign start      = playing && !prev_play_q;
  assign frame_edge = (frame_clk_edge == 2'b01);

  // Scroll amount for this frame: distance above the line, clamped.
  assign dy_gap = 10'(SCROLL_LINE) - Doodle_Y;
  always_comb begin
    scroll_calc = '0;
    if (Doodle_Y < 10'(SCROLL_LINE)) begin
      scroll_calc = (dy_gap > 10'(MAX_SCROLL)) ? 4'(MAX_SCROLL) : dy_gap[3:0];
    end
  end

  // Y is at most 479 and scroll at most 12, so the 10-bit sum cannot overflow.
  assign sum = y_q[idx_q] + {6'd0, scroll_q};

  // NOTE: every variable assigned here gets a default first; a path that left
  // one unassigned would infer a latch instead of combinational logic.
  always_comb begin
    fsm_d    = fsm_q;
    idx_d    = idx_q;
    scroll_d = scroll_q;
    x_d      = x_q;
    y_d      = y_q;
    score_d  = score_q;

    unique case (fsm_q)
      IDLE: begin
        // A frame edge in the same cycle as start is simply not looked at.
        if (start) begin
          fsm_d = LOAD;
          idx_d = '0;
        end
      end

      LOAD: begin
        y_d[idx_q] = layout_y(idx_q);
        x_d[idx_q] = (idx_q == 3'd0) ? X_CENTER : rand_x;
        score_d    = '0;
        idx_d      = idx_q + 3'd1;
        if (idx_q == 3'(PLAT_N - 1)) fsm_d = RUN;
      end

      RUN: begin
        if (!playing) begin
          fsm_d = IDLE;
        end else if (frame_edge) begin
          scroll_d = scroll_calc;
          if (scroll_calc != '0) begin
            fsm_d = UPDATE;
            idx_d = '0;
          end
        end
      end

      UPDATE: begin
        // Frame edges are ignored here; the sweep always runs to idx 7.
        if (sum >= 10'(H)) begin
          y_d[idx_q] = sum - 10'(H);
          x_d[idx_q] = rand_x;
          score_d    = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
        end else begin
          y_d[idx_q] = sum;
        end
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'(PLAT_N - 1)) fsm_d = playing ? RUN : IDLE;
      end

      default: fsm_d = IDLE;
    endcase

    busy_d = (fsm_d == LOAD) || (fsm_d == UPDATE);
  end

  // NOTE: the platform arrays are plain registers driving outputs that the
  // physics block reads every cycle, so they take a real reset value rather
  // than being treated as uninitialised storage.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fsm_q       <= IDLE;
      idx_q       <= '0;
      scroll_q    <= '0;
      score_q     <= '0;
      busy_q      <= 1'b0;
      prev_play_q <= 1'b0;
      for (int i = 0; i < PLAT_N; i++) begin
        y_q[i] <= layout_y(3'(i));
        x_q[i] <= X_CENTER;
      end
    end else begin
      fsm_q       <= fsm_d;
      idx_q       <= idx_d;
      scroll_q    <= scroll_d;
      score_q     <= score_d;
      busy_q      <= busy_d;
      prev_play_q <= playing;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  assign Platform_X    = x_q;
  assign Platform_Y    = y_q;
  assign platform_size = 8'(PLAT_SIZE);
  assign score         = score_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_platform_manager.sv
// ---------------------------------------------------------------------------
// tb_platform_manager
//   Directed stimulus for platform_manager. Each sweep-producing stimulus
//   pushes its expected end state (Y, X, score) into a queue; a monitor pops
//   and compares when busy falls. X values come from an LFSR reference
//   indexed by the cycle on which each platform is written.
// ---------------------------------------------------------------------------
module tb_platform_manager;

  typedef logic [7:0][9:0] plat_t;

  typedef struct packed {
    plat_t       y;
    plat_t       x;
    logic [15:0] score;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [1:0]  frame_clk_edge = 2'b00;
  logic [7:0]  state = 8'd0;
  logic [9:0]  Doodle_Y = 10'd300;
  plat_t       Platform_X;
  plat_t       Platform_Y;
  logic [7:0]  platform_size;
  logic [15:0] score;
  logic        busy;

  platform_manager dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_clk_edge (frame_clk_edge),
    .state          (state),
    .Doodle_Y       (Doodle_Y),
    .Platform_X     (Platform_X),
    .Platform_Y     (Platform_Y),
    .platform_size  (platform_size),
    .score          (score),
    .busy           (busy)
  );

  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Posedges since reset release == number of LFSR steps taken.
  int unsigned cyc;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic logic [15:0] lfsr_at(input int unsigned n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int unsigned i = 0; i < n; i++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    return l;
  endfunction

  function automatic logic [9:0] exp_x(input logic [15:0] l);
    logic [9:0] r;
    r = {1'b0, l[8:0]};
    if (r >= 10'd300) r = r - 10'd300;
    return 10'd140 + r;
  endfunction

  function automatic plat_t ys(input int a0, input int a1, input int a2, input int a3,
                               input int a4, input int a5, input int a6, input int a7);
    plat_t p;
    p[0] = 10'(a0); p[1] = 10'(a1); p[2] = 10'(a2); p[3] = 10'(a3);
    p[4] = 10'(a4); p[5] = 10'(a5); p[6] = 10'(a6); p[7] = 10'(a7);
    return p;
  endfunction

  // Bench's own view of the platform field.
  plat_t       m_x;
  plat_t       m_y;
  logic [15:0] m_score;

  exp_t  exp_q[$];
  string tag_q[$];

  // ---------------- monitor ----------------
  logic  busy_prev = 1'b0;
  int    busy_len  = 0;
  exp_t  e;
  string t;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      busy_prev = 1'b0;
      busy_len  = 0;
    end else begin
      if (busy) busy_len++;
      if (busy_prev && !busy) begin
        check("sweep_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          check($sformatf("%s busy_len", t), busy_len, 8);
          for (int i = 0; i < 8; i++) begin
            check($sformatf("%s y%0d", t, i), Platform_Y[i], e.y[i]);
            check($sformatf("%s x%0d", t, i), Platform_X[i], e.x[i]);
          end
          check($sformatf("%s score", t), score, e.score);
        end
        busy_len = 0;
      end
      busy_prev = busy;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Field must sit still: no sweep, values equal to the model.
  task automatic quiet(input string tag);
    repeat (6) begin
      @(negedge Clk);
      check({tag, " quiet busy"}, busy, 0);
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s hold y%0d", tag, i), Platform_Y[i], m_y[i]);
      check($sformatf("%s hold x%0d", tag, i), Platform_X[i], m_x[i]);
    end
    check({tag, " hold score"}, score, m_score);
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s y%0d", tag, i), Platform_Y[i], 32'(440 - 60 * i));
      check($sformatf("%s x%0d", tag, i), Platform_X[i], 290);
    end
    check({tag, " score"}, score, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " size"}, platform_size, 60);
  endtask

  task automatic start_game(input string tag, input bit with_edge);
    int unsigned c;
    tick();
    state = 8'd1;
    if (with_edge) frame_clk_edge = 2'b01;
    c = cyc;
    // LOAD idx k is written at the end of cycle c+1+k.
    m_y = ys(440, 380, 320, 260, 200, 140, 80, 20);
    m_x[0] = 10'd290;
    for (int k = 1; k < 8; k++) m_x[k] = exp_x(lfsr_at(c + 1 + k));
    m_score = 16'd0;
    exp_q.push_back('{y: m_y, x: m_x, score: m_score});
    tag_q.push_back(tag);
    tick();
    frame_clk_edge = 2'b00;
    drain();
    quiet(tag);
  endtask

  // One frame edge with hand-computed resulting Y table and score.
  task automatic frame(input string tag, input logic [9:0] dy, input plat_t ey,
                       input logic [15:0] escore, input bit extra_edge);
    int unsigned c;
    bit sweep;
    tick();
    Doodle_Y = dy;
    frame_clk_edge = 2'b01;
    c = cyc;
    sweep = (ey != m_y);
    // A Y that went down can only have wrapped; that platform gets a new X.
    for (int k = 0; k < 8; k++)
      if (ey[k] < m_y[k]) m_x[k] = exp_x(lfsr_at(c + 1 + k));
    m_y = ey;
    m_score = escore;
    if (sweep) begin
      exp_q.push_back('{y: m_y, x: m_x, score: m_score});
      tag_q.push_back(tag);
    end
    tick();
    frame_clk_edge = 2'b00;
    if (extra_edge) begin
      tick();
      tick();
      frame_clk_edge = 2'b01;  // lands on UPDATE idx 2
      tick();
      frame_clk_edge = 2'b00;
    end
    drain();
    quiet(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) tick();
    check_reset_values("por");
    Reset_n = 1'b1;
    tick();

    start_game("load", 1'b0);

    frame("s12",     10'd100, ys(452, 392, 332, 272, 212, 152,  92,  32), 16'd0, 1'b0);
    frame("s12b",    10'd148, ys(464, 404, 344, 284, 224, 164, 104,  44), 16'd0, 1'b0);
    frame("s6",      10'd154, ys(470, 410, 350, 290, 230, 170, 110,  50), 16'd0, 1'b0);
    frame("wrap",    10'd150, ys(  0, 420, 360, 300, 240, 180, 120,  60), 16'd1, 1'b0);
    frame("line160", 10'd160, ys(  0, 420, 360, 300, 240, 180, 120,  60), 16'd1, 1'b0);
    frame("above",   10'd200, ys(  0, 420, 360, 300, 240, 180, 120,  60), 16'd1, 1'b0);
    frame("s1",      10'd159, ys(  1, 421, 361, 301, 241, 181, 121,  61), 16'd1, 1'b0);
    frame("clamp",   10'd0,   ys( 13, 433, 373, 313, 253, 193, 133,  73), 16'd1, 1'b1);
    frame("g1",      10'd0,   ys( 25, 445, 385, 325, 265, 205, 145,  85), 16'd1, 1'b0);
    frame("g2",      10'd0,   ys( 37, 457, 397, 337, 277, 217, 157,  97), 16'd1, 1'b0);
    frame("g3",      10'd0,   ys( 49, 469, 409, 349, 289, 229, 169, 109), 16'd1, 1'b0);

    // Preload the score register to its ceiling, then wrap one platform.
    tick();
    force dut.score_d = 16'hFFFF;
    tick();
    release dut.score_d;
    @(negedge Clk);
    check("preload score", score, 16'hFFFF);
    m_score = 16'hFFFF;
    frame("sat",     10'd0,   ys( 61,   1, 421, 361, 301, 241, 181, 121), 16'hFFFF, 1'b0);

    // Leave play: field holds, frame edges ignored.
    tick();
    state = 8'd0;
    repeat (3) tick();
    frame_clk_edge = 2'b01;
    tick();
    frame_clk_edge = 2'b00;
    quiet("idle_hold");

    // Start and frame edge together: only the LOAD sweep may happen.
    start_game("restart", 1'b1);

    // Async reset in the middle of an UPDATE sweep.
    tick();
    Doodle_Y = 10'd0;
    frame_clk_edge = 2'b01;
    tick();
    frame_clk_edge = 2'b00;
    repeat (3) tick();
    check("mid busy", busy, 1);
    check("mid y0", Platform_Y[0], 452);
    check("mid y1", Platform_Y[1], 392);
    check("mid y2", Platform_Y[2], 332);
    check("mid y3", Platform_Y[3], 260);
    Reset_n = 1'b0;
    state   = 8'd0;
    #1;
    check_reset_values("mid_reset");
    tick();
    Reset_n = 1'b1;
    repeat (3) tick();
    check_reset_values("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
